// File: rtl/delay_line_pkg.sv
// Shared types for the delay-line controller.
//   dl_state_t : controller states. IDLE accepts a sample, READ waits for the
//                RAM read data, and HOLD presents the delayed sample until the
//                sink takes it.
package delay_line_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } dl_state_t;

endpackage

// File: rtl/delay_line_ctrl.sv
// Delay-line controller driving a dual-port sample RAM (read-first on a
// same-address collision, one-cycle read latency). Each accepted sample is
// written at wr_ptr. The sample written `offset` accepts earlier is read in
// the same cycle and presented on a valid/ready output.
//
// Ports:
//   clk, rst_n              clock; asynchronous active-low reset
//   in_valid/in_ready       input handshake; in_data sample, offset delay
//   out_valid/out_ready     output handshake; out_data delayed sample
//   ram_wr_en/addr, ram_din RAM write port
//   ram_rd_en/addr          RAM read port
//   ram_dout                RAM read data, one cycle after ram_rd_en
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_data,
  input  logic [A_WIDTH-1:0] offset,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic               ram_wr_en,
  output logic [A_WIDTH-1:0] ram_wr_addr,
  output logic [D_WIDTH-1:0] ram_din,
  output logic               ram_rd_en,
  output logic [A_WIDTH-1:0] ram_rd_addr,
  input  logic [D_WIDTH-1:0] ram_dout
);

  // Fill count saturates at the full depth, 2**A_WIDTH.
  localparam logic [A_WIDTH:0] FILL_MAX = {1'b1, {A_WIDTH{1'b0}}};

  dl_state_t          state;
  dl_state_t          state_nxt;
  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH:0]   fill_cnt;
  logic [A_WIDTH:0]   fill_l;
  logic [A_WIDTH-1:0] offset_l;
  logic [D_WIDTH-1:0] in_data_l;
  logic               accept;

  // Zero delay bypasses the RAM because a same-address read returns the old
  // contents. Slots not yet written since reset read as zero, which hides
  // whatever the RAM held before reset.
  function automatic logic [D_WIDTH-1:0] sel_out(
    input logic [A_WIDTH-1:0] off,
    input logic [A_WIDTH:0]   fill,
    input logic [D_WIDTH-1:0] byp,
    input logic [D_WIDTH-1:0] rd
  );
    if (off == '0)
      return byp;
    else if (fill < {1'b0, off})
      return '0;
    else
      return rd;
  endfunction

  // in_ready is held low while reset is asserted, not just after it.
  assign in_ready    = rst_n && (state == IDLE);
  assign accept      = in_valid && in_ready;

  assign ram_wr_en   = accept;
  assign ram_rd_en   = accept;
  assign ram_wr_addr = wr_ptr;
  assign ram_rd_addr = wr_ptr - offset;
  assign ram_din     = in_data;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      fill_l    <= '0;
      offset_l  <= '0;
      in_data_l <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;

      // Accept stage: write side advances and the request is latched.
      if (accept) begin
        wr_ptr    <= wr_ptr + 1'b1;
        offset_l  <= offset;
        in_data_l <= in_data;
        fill_l    <= fill_cnt;
        if (fill_cnt != FILL_MAX)
          fill_cnt <= fill_cnt + 1'b1;
      end

      // Read stage: RAM data is available now; load the output register.
      if (state == READ) begin
        out_valid <= 1'b1;
        out_data  <= sel_out(offset_l, fill_l, in_data_l, ram_dout);
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl together with a read-first dual-port RAM model.
module tb_delay_line_ctrl;

  localparam int AW = 9;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] offset = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_din;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_dout = '0;

  delay_line_ctrl #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .offset(offset),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout)
  );

  // Read-first RAM: a same-cycle read of the written address sees old data.
  logic [DW-1:0] mem [2**AW];
  initial for (int i = 0; i < 2**AW; i++) mem[i] = 8'hA5;
  always @(posedge clk) begin
    if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
    if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
  end

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] sb[$];
  logic [AW-1:0] mptr = '0;

  typedef struct {
    bit            rst;
    logic [DW-1:0] d;
    logic [AW-1:0] off;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input logic [DW-1:0] d, input logic [AW-1:0] off,
                     input logic [DW-1:0] exp);
    vec_t v;
    v.rst = r; v.d = d; v.off = off; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Output monitor: a transfer happens on the next edge when both are high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %0h, want none", out_data);
      end else begin
        chk("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  // Drive one sample, check the RAM port on the accepting cycle, queue the
  // expected delayed value.
  task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] off,
                      input logic [DW-1:0] exp);
    int w;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; offset = off;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w >= 20) break;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      chk("ram_wr_addr", {23'd0, ram_wr_addr}, {23'd0, mptr});
      chk("ram_rd_addr", {23'd0, ram_rd_addr}, {23'd0, 9'(mptr - off)});
      chk("ram_en", {30'd0, ram_wr_en, ram_rd_en}, 32'd3);
      sb.push_back(exp);
      mptr = mptr + 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_ram_en", {30'd0, ram_wr_en, ram_rd_en}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.delete();
    mptr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    // offset 4, inputs 1..10
    add(1, 1, 4, 0); add(0, 2, 4, 0); add(0, 3, 4, 0); add(0, 4, 4, 0); add(0, 5, 4, 1);
    add(0, 6, 4, 2); add(0, 7, 4, 3); add(0, 8, 4, 4); add(0, 9, 4, 5); add(0, 10, 4, 6);
    // zero offset bypass
    add(1, 8'h11, 0, 8'h11); add(0, 8'h22, 0, 8'h22); add(0, 8'h33, 0, 8'h33);
    // offset 2 then 5 without flush
    add(1, 1, 2, 0); add(0, 2, 2, 0); add(0, 3, 2, 1); add(0, 4, 2, 2); add(0, 5, 2, 3);
    add(0, 6, 2, 4); add(0, 7, 2, 5); add(0, 8, 2, 6); add(0, 9, 2, 7); add(0, 10, 2, 8);
    add(0, 11, 5, 6); add(0, 12, 5, 7); add(0, 13, 5, 8);

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        drain();
        do_reset();
      end
      send(vecs[i].d, vecs[i].off, vecs[i].exp);
    end
    drain();

    // Wrap-around with maximum offset
    do_reset();
    for (int n = 0; n < 600; n++)
      send(8'(n), 9'd511, (n < 511) ? 8'd0 : 8'(n - 511));
    drain();

    // Reset while holding an output
    do_reset();
    out_ready = 1'b0;
    send(8'h55, 9'd0, 8'h55);
    w = 0;
    while (!out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("hold_reached", {31'd0, out_valid}, 32'd1);
    do_reset();
    out_ready = 1'b1;
    send(7, 3, 0); send(8, 3, 0); send(9, 3, 0); send(10, 3, 7);
    drain();

    // Backpressure: five cycles in HOLD with out_ready low
    out_ready = 1'b0;
    send(8'h0B, 9'd2, 8'd9);
    w = 0;
    while (!out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_data", {24'd0, out_data}, {24'd0, sb.size() != 0 ? sb[0] : 8'hFF});
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_ram_en", {30'd0, ram_wr_en, ram_rd_en}, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data = 8'hEE;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
